// File: rtl/pix_pkg.sv
// Shared definitions for the palette pixel decoder.
//   - Mode numbers for the three palette modes used by the product.
//   - Reset-time palette values (HI for the all-ones index, MID for the others).
//   - Default mode-enable mask.
//   - default_entry(): the reset value of one palette entry.
package pix_pkg;

    localparam int MODE_LOGO  = 7;
    localparam int MODE_CUBES = 6;
    localparam int MODE_CHOCO = 1;

    localparam logic [7:0] LOGO_HI = 8'hFF;
    localparam logic [7:0] LOGO_MID = 8'h64;
    localparam logic [7:0] STD_HI = 8'h96;
    localparam logic [7:0] STD_MID = 8'h32;

    localparam logic [7:0] DEF_MODE_EN = 8'b1100_0010;

    // Index 0 is always black.
    // The all-ones index gets HI, and every other index gets MID.
    // Disabled modes hold zero everywhere.
    function automatic logic [7:0] default_entry(input logic en,
                                                 input logic is_logo,
                                                 input logic idx_zero,
                                                 input logic idx_ones);
        logic [7:0] v;
        v = 8'h00;
        if (en && !idx_zero) begin
            if (idx_ones) v = is_logo ? LOGO_HI : STD_HI;
            else          v = is_logo ? LOGO_MID : STD_MID;
        end
        return v;
    endfunction

endpackage

// File: rtl/pix_palette_rf.sv
// Palette register file: 2**SEL_W modes x 2**IDX_W entries, PIX_W bits each.
// A read is combinational. A write takes effect at the clock edge, so a read
// of the same entry in that cycle still returns the old value.
// The asynchronous reset reloads the default palette.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   we, wsel, widx, wdata write strobe, mode, entry, value
//   rsel, ridx, rdata     read mode, entry, value
module pix_palette_rf
    import pix_pkg::*;
#(
    parameter int IDX_W = 2,
    parameter int PIX_W = 8,
    parameter int SEL_W = 3,
    parameter logic [(2**SEL_W)-1:0] MODE_EN = DEF_MODE_EN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [SEL_W-1:0] wsel,
    input  logic [IDX_W-1:0] widx,
    input  logic [PIX_W-1:0] wdata,
    input  logic [SEL_W-1:0] rsel,
    input  logic [IDX_W-1:0] ridx,
    output logic [PIX_W-1:0] rdata
);

    localparam int NSEL = 2**SEL_W;
    localparam int NIDX = 2**IDX_W;

    logic [PIX_W-1:0] mem [NSEL][NIDX];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NSEL; s++) begin
                for (int i = 0; i < NIDX; i++) begin
                    mem[s][i] <= PIX_W'(default_entry(MODE_EN[s], s == MODE_LOGO,
                                                      i == 0, i == NIDX - 1));
                end
            end
        end else if (we && MODE_EN[wsel]) begin
            // Writes to disabled modes are dropped, so those entries stay zero.
            mem[wsel][widx] <= wdata;
        end
    end

    assign rdata = mem[rsel][ridx];

endmodule

// File: rtl/pix_decoder_stream.sv
// Streaming palette decoder.
// Each accepted (s_sel, s_idx) pixel is looked up in the palette and
// registered into a single output stage, which gives a latency of one cycle.
// Handshake: a beat transfers on a channel when valid && ready are both high
// at the rising edge. While valid is high and ready is low, the producer
// holds its payload stable.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   s_valid/s_ready/s_idx/s_sel/s_last   input pixel stream
//   m_valid/m_ready/m_pix/m_last         decoded output stream
//   cfg_we/cfg_sel/cfg_idx/cfg_data      palette write port
//   err_sel, err_clr                sticky disabled-mode flag and its clear
//   frame_cnt                       count of accepted s_last beats (wraps)
module pix_decoder_stream
    import pix_pkg::*;
#(
    parameter int IDX_W = 2,
    parameter int PIX_W = 8,
    parameter int SEL_W = 3,
    parameter logic [(2**SEL_W)-1:0] MODE_EN = DEF_MODE_EN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [IDX_W-1:0] s_idx,
    input  logic [SEL_W-1:0] s_sel,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_pix,
    output logic             m_last,
    input  logic             cfg_we,
    input  logic [SEL_W-1:0] cfg_sel,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [PIX_W-1:0] cfg_data,
    output logic             err_sel,
    input  logic             err_clr,
    output logic [15:0]      frame_cnt
);

    logic [PIX_W-1:0] pal_data;
    logic             mode_ok;
    logic             in_xfer;

    pix_palette_rf #(
        .IDX_W   (IDX_W),
        .PIX_W   (PIX_W),
        .SEL_W   (SEL_W),
        .MODE_EN (MODE_EN)
    ) u_palette (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (cfg_we),
        .wsel  (cfg_sel),
        .widx  (cfg_idx),
        .wdata (cfg_data),
        .rsel  (s_sel),
        .ridx  (s_idx),
        .rdata (pal_data)
    );

    // The output register can take a new beat when it is empty or is being
    // drained in this same cycle.
    assign s_ready = !m_valid || m_ready;
    assign in_xfer = s_valid && s_ready;
    assign mode_ok = MODE_EN[s_sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_pix   <= '0;
            m_last  <= 1'b0;
        end else if (in_xfer) begin
            m_valid <= 1'b1;
            m_pix   <= mode_ok ? pal_data : '0;
            m_last  <= s_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

    // A new error takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sel <= 1'b0;
        end else if (in_xfer && !mode_ok) begin
            err_sel <= 1'b1;
        end else if (err_clr) begin
            err_sel <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 16'd0;
        end else if (in_xfer && s_last) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pix_decoder_stream.sv
module tb_pix_decoder_stream;

    logic       clk;
    logic       rst_n;
    logic       s_valid;
    logic       s_ready;
    logic [1:0] s_idx;
    logic [2:0] s_sel;
    logic       s_last;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_pix;
    logic       m_last;
    logic       cfg_we;
    logic [2:0] cfg_sel;
    logic [1:0] cfg_idx;
    logic [7:0] cfg_data;
    logic       err_sel;
    logic       err_clr;
    logic [15:0] frame_cnt;

    int total;
    int bad;
    int exp_frames;
    logic [8:0] exp_q[$];
    logic [7:0] logo_exp [4];

    pix_decoder_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_idx     (s_idx),
        .s_sel     (s_sel),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_pix     (m_pix),
        .m_last    (m_last),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_idx   (cfg_idx),
        .cfg_data  (cfg_data),
        .err_sel   (err_sel),
        .err_clr   (err_clr),
        .frame_cnt (frame_cnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        bad++;
        total++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected beat for every output transfer.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_unexpected: got %0h expected none", {m_last, m_pix});
            end else begin
                check("out_beat", {23'd0, m_last, m_pix}, {23'd0, exp_q.pop_front()});
            end
        end
    end

    // Drives one pixel and waits until it is accepted. The call returns 1 time unit after the accepting edge.
    task automatic send(input logic [2:0] sel, input logic [1:0] idx,
                        input logic last, input logic [7:0] exp_pix);
        bit ok;
        ok = 0;
        s_valid = 1'b1;
        s_sel   = sel;
        s_idx   = idx;
        s_last  = last;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            check("send_timeout", 32'd0, 32'd1);
        end else begin
            exp_q.push_back({last, exp_pix});
            if (last) exp_frames++;
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logo_exp = '{8'h00, 8'h64, 8'h64, 8'hFF};
        total = 0; bad = 0; exp_frames = 0;
        rst_n = 1'b0; s_valid = 1'b0; s_idx = '0; s_sel = '0; s_last = 1'b0;
        m_ready = 1'b1; cfg_we = 1'b0; cfg_sel = '0; cfg_idx = '0; cfg_data = '0;
        err_clr = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_pix", {24'd0, m_pix}, 32'd0);
        check("rst_m_last", {31'd0, m_last}, 32'd0);
        check("rst_err", {31'd0, err_sel}, 32'd0);
        check("rst_frame", {16'd0, frame_cnt}, 32'd0);
        check("rst_s_ready", {31'd0, s_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Logo mode, back-to-back, with a latency of one cycle
        send(3'd7, 2'd0, 1'b0, 8'h00);
        @(negedge clk);
        check("latency_valid", {31'd0, m_valid}, 32'd1);
        check("latency_pix", {24'd0, m_pix}, 32'h00);
        @(posedge clk); #1;
        send(3'd7, 2'd1, 1'b0, 8'h64);
        send(3'd7, 2'd2, 1'b0, 8'h64);
        send(3'd7, 2'd3, 1'b1, 8'hFF);
        send(3'd6, 2'd1, 1'b0, 8'h32);
        send(3'd1, 2'd3, 1'b0, 8'h96);
        idle(2);
        check("drain_valid", {31'd0, m_valid}, 32'd0);

        // Backpressure hold
        m_ready = 1'b0;
        send(3'd6, 2'd3, 1'b0, 8'h96);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, m_valid}, 32'd1);
            check("hold_pix", {24'd0, m_pix}, 32'h96);
            check("hold_s_ready", {31'd0, s_ready}, 32'd0);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("single_xfer", {31'd0, m_valid}, 32'd0);
        @(posedge clk); #1;

        // A write and a read of the same entry in one cycle: the read sees the old value
        cfg_we = 1'b1; cfg_sel = 3'd1; cfg_idx = 2'd2; cfg_data = 8'hAB;
        send(3'd1, 2'd2, 1'b0, 8'h32);
        cfg_we = 1'b0;
        send(3'd1, 2'd2, 1'b0, 8'hAB);
        // A write to a disabled mode is ignored
        cfg_we = 1'b1; cfg_sel = 3'd3; cfg_idx = 2'd1; cfg_data = 8'h55;
        idle(1);
        cfg_we = 1'b0;
        idle(2);
        check("err_before", {31'd0, err_sel}, 32'd0);

        // Disabled mode and the error flag
        send(3'd3, 2'd1, 1'b0, 8'h00);
        @(negedge clk);
        check("err_set", {31'd0, err_sel}, 32'd1);
        @(posedge clk); #1;
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        @(negedge clk);
        check("err_cleared", {31'd0, err_sel}, 32'd0);
        @(posedge clk); #1;
        err_clr = 1'b1;
        send(3'd3, 2'd2, 1'b0, 8'h00);
        err_clr = 1'b0;
        @(negedge clk);
        check("err_set_wins", {31'd0, err_sel}, 32'd1);
        @(posedge clk); #1;
        send(3'd0, 2'd3, 1'b0, 8'h00);

        // Modify the palette, then reset mid-stream
        cfg_we = 1'b1; cfg_sel = 3'd7; cfg_idx = 2'd1; cfg_data = 8'h11;
        idle(1);
        cfg_we = 1'b0;
        send(3'd7, 2'd1, 1'b1, 8'h11);
        idle(2);
        check("frame_pre_rst", {16'd0, frame_cnt}, exp_frames);
        m_ready = 1'b0;
        send(3'd7, 2'd3, 1'b0, 8'hFF);
        check("pre_rst_valid", {31'd0, m_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_m_valid", {31'd0, m_valid}, 32'd0);
        check("async_m_pix", {24'd0, m_pix}, 32'd0);
        check("async_frame", {16'd0, frame_cnt}, 32'd0);
        check("async_err", {31'd0, err_sel}, 32'd0);
        check("async_s_ready", {31'd0, s_ready}, 32'd1);
        exp_q.delete();
        exp_frames = 0;
        @(negedge clk);
        rst_n = 1'b1;
        m_ready = 1'b1;
        @(posedge clk); #1;
        send(3'd7, 2'd1, 1'b0, 8'h64);
        idle(2);

        // Frame counter wrap
        for (int i = 0; i < 65536; i++) begin
            send(3'd7, 2'(i), 1'b1, logo_exp[i % 4]);
        end
        @(negedge clk);
        check("frame_wrap0", {16'd0, frame_cnt}, 32'd0);
        @(posedge clk); #1;
        send(3'd6, 2'd0, 1'b1, 8'h00);
        @(negedge clk);
        check("frame_wrap1", {16'd0, frame_cnt}, 32'd1);
        check("frame_model", {16'd0, frame_cnt}, {16'd0, exp_frames[15:0]});
        @(posedge clk); #1;

        idle(3);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pix_decoder_stream.md
PIX_DECODER_STREAM -- requirements
Module: pix_decoder_stream

Interface
REQ-001 Parameter IDX_W, default 2: width of pixel index (palette entries per mode = 2**IDX_W).
REQ-002 Parameter PIX_W, default 8: width of decoded pixel.
REQ-003 Parameter SEL_W, default 3: width of mode select (modes = 2**SEL_W).
REQ-004 Parameter MODE_EN, default 8'b1100_0010: bit m set = mode m valid (7 LOGO, 6 CUBES, 1 CHOCO_BAR).
REQ-005 clk  in  1  single clock, all state rising-edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 s_valid  in  1  input pixel valid.
REQ-008 s_ready  out  1  block accepts input pixel.
REQ-009 s_idx  in  IDX_W  pixel index.
REQ-010 s_sel  in  SEL_W  mode select for this pixel.
REQ-011 s_last  in  1  last pixel of frame.
REQ-012 m_valid  out  1  output pixel valid.
REQ-013 m_ready  in  1  downstream accepts output.
REQ-014 m_pix  out  PIX_W  decoded pixel.
REQ-015 m_last  out  1  s_last delayed with pixel.
REQ-016 cfg_we  in  1  palette write strobe.
REQ-017 cfg_sel  in  SEL_W  palette mode to write.
REQ-018 cfg_idx  in  IDX_W  palette entry to write.
REQ-019 cfg_data  in  PIX_W  palette value.
REQ-020 err_sel  out  1  sticky flag: disabled mode accepted since reset/clear.
REQ-021 err_clr  in  1  clears err_sel.
REQ-022 frame_cnt  out  16  completed frames (accepted s_last beats), wraps 0xFFFF->0.

Function
REQ-023 Palette: 2**SEL_W x 2**IDX_W registers, PIX_W each.
REQ-024 Input transfer when s_valid && s_ready; output transfer when m_valid && m_ready.
REQ-025 s_ready = !m_valid || m_ready (single output register, full throughput, 1-cycle latency).
REQ-026 Accepted pixel: m_pix = palette[s_sel][s_idx] if MODE_EN[s_sel], else 0; m_last = s_last; m_valid set next cycle.
REQ-027 m_valid cleared after output transfer with no simultaneous input transfer; m_pix/m_last held stable while m_valid && !m_ready.
REQ-028 cfg_we writes palette[cfg_sel][cfg_idx] = cfg_data at edge; writes to disabled modes ignored.
REQ-029 Write and read of same entry in same cycle: decoded pixel uses old value; new value from next accepted pixel.
REQ-030 Accepted pixel with !MODE_EN[s_sel] sets err_sel next cycle.
REQ-031 err_clr && new error in same cycle: err_sel stays 1 (set wins).
REQ-032 frame_cnt increments on each input transfer with s_last = 1.

Reset
REQ-033 rst_n low: m_valid=0, m_pix=0, m_last=0, err_sel=0, frame_cnt=0, immediately, independent of clk.
REQ-034 Palette defaults at reset, enabled modes: index 0 -> 0x00; index all-ones -> HI; other indices -> MID. Mode 7: HI=0xFF, MID=0x64. Modes 6, 1: HI=0x96, MID=0x32. Disabled modes: all 0. (PIX_W != 8: values zero-extended/truncated LSB-aligned.)
REQ-035 Reset mid-stream: in-flight output pixel discarded, not replayed; s_ready = 1 during and after reset.

Structure
REQ-036 Shared package pix_pkg: mode constants (MODE_LOGO=7, MODE_CUBES=6, MODE_CHOCO=1), default HI/MID values, default MODE_EN.
REQ-037 One sub-module: pix_palette_rf (palette register file, async read, sync write, async reset to defaults).

Verification
REQ-038 Reset, then s_sel=7, s_idx=0,1,2,3 back-to-back, m_ready=1 -> m_pix 0x00,0x64,0x64,0xFF, one per cycle, 1-cycle latency.
REQ-039 s_sel=6 idx=3 with m_ready=0 for 5 cycles -> m_valid=1, m_pix=0x96 held, s_ready=0; m_ready=1 -> single transfer.
REQ-040 cfg_we sel=1 idx=2 data=0xAB same cycle as pixel sel=1 idx=2 -> that pixel 0x32; next such pixel 0xAB.
REQ-041 Pixel sel=3 -> m_pix=0x00, err_sel=1 next cycle; err_clr pulse -> err_sel=0; err_clr with sel=3 pixel together -> err_sel=1.
REQ-042 65537 beats with s_last=1 -> frame_cnt=1 (wrap); m_last matches each beat.
REQ-043 rst_n low mid-stream with m_valid=1 -> m_valid=0 asynchronously, palette back to defaults, frame_cnt=0.
